// File: rtl/axi_read_arbiter_if.sv
// Shared AXI read definitions and the read-channel bundle.
//   _pkg_riscv_basic : bus widths and the zero/OKAY encodings used as idle values.
//   axi_read_if      : AR + R channel signals.
//                      master modport = the side issuing AR and accepting R.
//                      slave  modport = the side accepting AR and returning R.
package _pkg_riscv_basic;
   localparam int ADDR_WIDTH        = 32;
   localparam int DATA_WIDTH        = 32;
   localparam int AXI_ARLEN_WIDTH   = 8;
   localparam int AXI_ARSIZE_WIDTH  = 3;
   localparam int AXI_ARBURST_WIDTH = 2;
   localparam int AXI_RESP_WIDTH    = 2;

   localparam logic [AXI_ARSIZE_WIDTH-1:0]  AXI_ARSIZE_ZERO  = 3'b000;
   localparam logic [AXI_ARBURST_WIDTH-1:0] AXI_ARBURST_ZERO = 2'b00;
   localparam logic [AXI_RESP_WIDTH-1:0]    AXI_RESP_OKAY    = 2'b00;
   localparam logic [AXI_RESP_WIDTH-1:0]    AXI_RESP_SLVERR  = 2'b10;
   localparam logic [AXI_RESP_WIDTH-1:0]    AXI_RESP_DECERR  = 2'b11;
endpackage

interface axi_read_if #(
   parameter int ADDR_WIDTH      = _pkg_riscv_basic::ADDR_WIDTH,
   parameter int DATA_WIDTH      = _pkg_riscv_basic::DATA_WIDTH,
   parameter int AXI_ARLEN_WIDTH = _pkg_riscv_basic::AXI_ARLEN_WIDTH
) ();
   logic [ADDR_WIDTH-1:0]                          araddr;
   logic [AXI_ARLEN_WIDTH-1:0]                     arlen;
   logic [_pkg_riscv_basic::AXI_ARSIZE_WIDTH-1:0]  arsize;
   logic [_pkg_riscv_basic::AXI_ARBURST_WIDTH-1:0] arburst;
   logic                                           arvalid;
   logic                                           arready;
   logic [DATA_WIDTH-1:0]                          rdata;
   logic [_pkg_riscv_basic::AXI_RESP_WIDTH-1:0]    rresp;
   logic                                           rlast;
   logic                                           rvalid;
   logic                                           rready;

   modport master (
      output araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-to-one round-robin AXI read arbiter.
// Shares one downstream read port between requester 0 (I-cache refill) and
// requester 1 (D-cache refill). One burst in flight at a time; the R burst is
// routed combinationally back to the owner. Each burst's rlast is checked
// against its arlen.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   s0, s1     : upstream requesters (slave side of axi_read_if)
//   m          : shared downstream port (master side of axi_read_if)
//   grant_id   : owner of m, meaningful while busy
//   busy       : a burst is being addressed or returned
//   burst_err  : sticky, a burst ended on a beat other than arlen
module axi_read_arbiter #(
   parameter int ADDR_WIDTH      = _pkg_riscv_basic::ADDR_WIDTH,
   parameter int DATA_WIDTH      = _pkg_riscv_basic::DATA_WIDTH,
   parameter int AXI_ARLEN_WIDTH = _pkg_riscv_basic::AXI_ARLEN_WIDTH,
   parameter bit RESET_PRIO      = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   axi_read_if.slave   s0,
   axi_read_if.slave   s1,
   axi_read_if.master  m,
   output logic        grant_id,
   output logic        busy,
   output logic        burst_err
);

   localparam int SW = _pkg_riscv_basic::AXI_ARSIZE_WIDTH;
   localparam int BW = _pkg_riscv_basic::AXI_ARBURST_WIDTH;
   localparam int RW = _pkg_riscv_basic::AXI_RESP_WIDTH;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]      addr;
      logic [AXI_ARLEN_WIDTH-1:0] len;
      logic [SW-1:0]              size;
      logic [BW-1:0]              burst;
      logic                       valid;
   } ar_req_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [RW-1:0]         resp;
      logic                  last;
      logic                  valid;
   } r_rsp_t;

   state_t                     state_q, state_d;
   logic                       grant_q, grant_d;
   logic                       last_grant_q, last_grant_d;
   logic                       burst_err_q, burst_err_d;
   logic [AXI_ARLEN_WIDTH-1:0] len_q, len_d;
   logic [AXI_ARLEN_WIDTH:0]   beat_q, beat_d;

   ar_req_t ar_sel;
   r_rsp_t  r_dn;
   r_rsp_t  r_idle;
   logic    rready_sel;
   logic    ar_hs;
   logic    r_hs;
   logic    len_hit;

   // Granted requester's AR fields and rready; grant_q is locked outside IDLE
   // so this mux is stable for the whole transaction.
   always_comb begin
      ar_sel = '0;
      if (grant_q) begin
         ar_sel.addr  = s1.araddr;
         ar_sel.len   = s1.arlen;
         ar_sel.size  = s1.arsize;
         ar_sel.burst = s1.arburst;
         ar_sel.valid = s1.arvalid;
         rready_sel   = s1.rready;
      end else begin
         ar_sel.addr  = s0.araddr;
         ar_sel.len   = s0.arlen;
         ar_sel.size  = s0.arsize;
         ar_sel.burst = s0.arburst;
         ar_sel.valid = s0.arvalid;
         rready_sel   = s0.rready;
      end
   end

   always_comb begin
      r_dn.data  = m.rdata;
      r_dn.resp  = m.rresp;
      r_dn.last  = m.rlast;
      r_dn.valid = m.rvalid;
      r_idle      = '0;
      r_idle.resp = _pkg_riscv_basic::AXI_RESP_OKAY;
   end

   assign ar_hs   = (state_q == ADDR) && ar_sel.valid && m.arready;
   assign r_hs    = (state_q == DATA) && m.rvalid && rready_sel;
   assign len_hit = (beat_q == {1'b0, len_q});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= ~RESET_PRIO;
         burst_err_q  <= 1'b0;
         len_q        <= '0;
         beat_q       <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         burst_err_q  <= burst_err_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      burst_err_d  = burst_err_q;
      len_d        = len_q;
      beat_d       = beat_q;

      m.araddr  = '0;
      m.arlen   = '0;
      m.arsize  = _pkg_riscv_basic::AXI_ARSIZE_ZERO;
      m.arburst = _pkg_riscv_basic::AXI_ARBURST_ZERO;
      m.arvalid = 1'b0;
      m.rready  = 1'b0;

      s0.arready = 1'b0;
      s1.arready = 1'b0;
      {s0.rdata, s0.rresp, s0.rlast, s0.rvalid} = r_idle;
      {s1.rdata, s1.rresp, s1.rlast, s1.rvalid} = r_idle;

      unique case (state_q)
         IDLE: begin
            if (s0.arvalid || s1.arvalid) begin
               // On a tie the requester not served last goes first.
               if (s0.arvalid && s1.arvalid) grant_d = ~last_grant_q;
               else                          grant_d = s1.arvalid;
               state_d = ADDR;
            end
         end
         ADDR: begin
            m.araddr  = ar_sel.addr;
            m.arlen   = ar_sel.len;
            m.arsize  = ar_sel.size;
            m.arburst = ar_sel.burst;
            m.arvalid = ar_sel.valid;
            if (grant_q) s1.arready = m.arready;
            else         s0.arready = m.arready;
            if (ar_hs) begin
               len_d   = ar_sel.len;
               beat_d  = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            m.rready = rready_sel;
            if (grant_q) {s1.rdata, s1.rresp, s1.rlast, s1.rvalid} = r_dn;
            else         {s0.rdata, s0.rresp, s0.rlast, s0.rvalid} = r_dn;
            if (r_hs) begin
               beat_d = beat_q + 1'b1;
               // Termination follows rlast alone; a mismatch against arlen
               // is only flagged.
               if (m.rlast) begin
                  if (!len_hit) burst_err_d = 1'b1;
                  last_grant_d = grant_q;
                  state_d      = IDLE;
               end else if (len_hit) begin
                  burst_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_id  = grant_q;
   assign busy      = (state_q != IDLE);
   assign burst_err = burst_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;

   localparam bit RP = 1'b0;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   axi_read_if s0_if ();
   axi_read_if s1_if ();
   axi_read_if m_if ();

   logic grant_id, busy, burst_err;

   // requester-side stimulus
   logic        arv  [2];
   logic [31:0] addr [2];
   logic [7:0]  alen [2];
   logic        rrdy [2];
   // downstream slave stimulus
   logic        m_arready;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rlast;

   assign s0_if.arvalid = arv[0];
   assign s0_if.araddr  = addr[0];
   assign s0_if.arlen   = alen[0];
   assign s0_if.arsize  = 3'd2;
   assign s0_if.arburst = 2'b01;
   assign s0_if.rready  = rrdy[0];
   assign s1_if.arvalid = arv[1];
   assign s1_if.araddr  = addr[1];
   assign s1_if.arlen   = alen[1];
   assign s1_if.arsize  = 3'd2;
   assign s1_if.arburst = 2'b01;
   assign s1_if.rready  = rrdy[1];
   assign m_if.arready  = m_arready;
   assign m_if.rvalid   = m_rvalid;
   assign m_if.rdata    = m_rdata;
   assign m_if.rresp    = m_rresp;
   assign m_if.rlast    = m_rlast;

   axi_read_arbiter #(.RESET_PRIO(RP)) dut (
      .clk       (clk),
      .rst       (rst),
      .s0        (s0_if),
      .s1        (s1_if),
      .m         (m_if),
      .grant_id  (grant_id),
      .busy      (busy),
      .burst_err (burst_err)
   );

   int n_pass = 0;
   int n_chk  = 0;
   logic model_last;

   task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic up_arready(input int i);
      return (i != 0) ? s1_if.arready : s0_if.arready;
   endfunction
   function automatic logic up_rvalid(input int i);
      return (i != 0) ? s1_if.rvalid : s0_if.rvalid;
   endfunction
   function automatic logic up_rlast(input int i);
      return (i != 0) ? s1_if.rlast : s0_if.rlast;
   endfunction
   function automatic logic [1:0] up_rresp(input int i);
      return (i != 0) ? s1_if.rresp : s0_if.rresp;
   endfunction
   function automatic logic [31:0] up_rdata(input int i);
      return (i != 0) ? s1_if.rdata : s0_if.rdata;
   endfunction

   task automatic clear_inputs();
      for (int i = 0; i < 2; i++) begin
         arv[i] = 1'b0; addr[i] = '0; alen[i] = '0; rrdy[i] = 1'b0;
      end
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_last = ~RP;
   endtask

   // ---------------- table-driven traffic scenarios ----------------
   typedef struct {
      int n0;          // bursts queued on requester 0
      int n1;          // bursts queued on requester 1
      int len;         // arlen for all bursts, -1 = random 0..7
      int err_beat;    // slave ends bursts on this beat when < arlen, -1 = never
      int rmode;       // requester rready: 0 always, 1 toggle, 2 random
      int amode;       // 1 = random arready / rvalid gaps downstream
      bit do_reset;
      bit exp_err;     // expected burst_err after the scenario
      int exp_first;   // expected owner of the first burst
   } scen_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } req_t;

   task automatic run_traffic(input scen_t sc, input string tag);
      req_t r0[$], r1[$], r;
      int   exp_g[$];
      int   c0, c1, w, eg;
      logic lastg;
      bit   act = 0, hold = 0, prev_arv = 0;
      int   g = 0, beat = 0, rlast_at = 0, blen = 0;
      int   cyc = 0, end_cyc = -1, first_g = -1;
      int   beats_got = 0, beats_exp = 0, viol = 0;

      if (sc.do_reset) do_reset();
      for (int i = 0; i < sc.n0; i++) begin
         r.addr = 32'h1000_0000 | ($urandom & 32'h0000_fff0);
         r.len  = (sc.len < 0) ? 8'($urandom_range(0, 7)) : 8'(sc.len);
         r0.push_back(r);
      end
      for (int i = 0; i < sc.n1; i++) begin
         r.addr = 32'h2000_0000 | ($urandom & 32'h0000_fff0);
         r.len  = (sc.len < 0) ? 8'($urandom_range(0, 7)) : 8'(sc.len);
         r1.push_back(r);
      end
      // Reference order: every requester keeps its arvalid up while it has
      // work, so whenever both queues are non-empty they alternate.
      c0 = sc.n0; c1 = sc.n1; lastg = model_last;
      while (c0 > 0 || c1 > 0) begin
         if (c0 > 0 && c1 > 0) w = lastg ? 0 : 1;
         else                  w = (c0 > 0) ? 0 : 1;
         exp_g.push_back(w);
         if (w != 0) c1--; else c0--;
         lastg = w[0];
      end

      while ((exp_g.size() > 0 || act) && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         arv[0] = (r0.size() > 0);
         if (r0.size() > 0) begin addr[0] = r0[0].addr; alen[0] = r0[0].len; end
         arv[1] = (r1.size() > 0);
         if (r1.size() > 0) begin addr[1] = r1[0].addr; alen[1] = r1[0].len; end
         for (int i = 0; i < 2; i++)
            rrdy[i] = (sc.rmode == 0) ? 1'b1 : (sc.rmode == 1) ? cyc[0] : 1'($urandom);
         m_arready = sc.amode != 0 ? 1'($urandom) : 1'b1;
         if (act) begin
            if (!hold) begin
               m_rvalid = sc.amode != 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
               m_rdata  = $urandom;
               m_rresp  = 2'($urandom);
               m_rlast  = (beat == rlast_at);
            end
         end else begin
            m_rvalid = 1'b0; m_rlast = 1'b0;
         end
         #1;
         if (act) begin
            if (m_if.rready !== rrdy[g]) viol++;
            if (up_rvalid(1 - g) !== 1'b0 || up_rdata(1 - g) !== 32'h0) viol++;
            if (up_rvalid(g) !== m_rvalid) viol++;
            if (m_rvalid && m_if.rready) begin
               chk_eq({tag, "_rdata"}, up_rdata(g), m_rdata);
               chk_eq({tag, "_rresp"}, up_rresp(g), m_rresp);
               chk_eq({tag, "_rlast"}, up_rlast(g), m_rlast);
               beats_got++;
               hold = 0;
               if (m_rlast) begin
                  act = 0; end_cyc = cyc; model_last = g[0];
               end
               beat++;
            end else begin
               hold = m_rvalid;
            end
         end
         eg = (exp_g.size() > 0) ? exp_g[0] : g;
         if (m_if.arvalid === 1'b1) begin
            if (!prev_arv && end_cyc >= 0) chk_eq({tag, "_turnaround"}, cyc - end_cyc, 2);
            if (up_arready(eg) !== m_if.arready || up_arready(1 - eg) !== 1'b0) viol++;
            if (m_if.arready && exp_g.size() > 0) begin
               r = (eg != 0) ? r1[0] : r0[0];
               chk_eq({tag, "_grant"}, grant_id, eg);
               chk_eq({tag, "_araddr"}, m_if.araddr, r.addr);
               chk_eq({tag, "_arlen"}, m_if.arlen, r.len);
               if (first_g < 0) first_g = grant_id;
               if (eg != 0) void'(r1.pop_front()); else void'(r0.pop_front());
               void'(exp_g.pop_front());
               g = eg; act = 1; beat = 0; hold = 0; blen = r.len;
               rlast_at = (sc.err_beat >= 0 && sc.err_beat < blen) ? sc.err_beat : blen;
               beats_exp += rlast_at + 1;
            end
         end
         prev_arv = (m_if.arvalid === 1'b1);
      end
      chk_eq({tag, "_done_in_budget"}, cyc < 4000, 1);
      @(negedge clk);
      m_rvalid = 1'b0; m_rlast = 1'b0;
      for (int i = 0; i < 2; i++) arv[i] = 1'b0;
      #1;
      chk_eq({tag, "_busy_end"}, busy, 0);
      chk_eq({tag, "_burst_err"}, burst_err, sc.exp_err);
      chk_eq({tag, "_protocol_viol"}, viol, 0);
      chk_eq({tag, "_beats"}, beats_got, beats_exp);
      chk_eq({tag, "_first_grant"}, first_g, sc.exp_first);
   endtask

   scen_t tbl[9];

   initial begin
      //        n0 n1 len err rm am rst err first
      tbl[0] = '{1, 1,  1, -1, 0, 0, 1, 0, 0};  // tie after reset
      tbl[1] = '{1, 1,  1, -1, 0, 0, 0, 0, 0};  // repeat tie, s1 was last
      tbl[2] = '{1, 0,  2, -1, 0, 0, 0, 0, 0};  // s0 alone
      tbl[3] = '{1, 2,  2, -1, 0, 0, 0, 0, 1};  // s1 back-to-back: 1,0,1
      tbl[4] = '{1, 0,  7, -1, 1, 0, 0, 0, 0};  // rready toggling, 8 beats
      tbl[5] = '{0, 1,  0, -1, 0, 0, 0, 0, 1};  // arlen=0 single beat
      tbl[6] = '{1, 0,  3,  1, 0, 0, 0, 1, 0};  // early rlast on beat 1
      tbl[7] = '{0, 1,  2, -1, 0, 0, 0, 1, 1};  // error flag is sticky
      tbl[8] = '{3, 3, -1, -1, 2, 1, 1, 0, 0};  // random mix after reset

      clear_inputs();
      model_last = ~RP;

      // ---- reset state ----
      do_reset();
      #1;
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_grant_id", grant_id, 0);
      chk_eq("rst_burst_err", burst_err, 0);
      chk_eq("rst_m_arvalid", m_if.arvalid, 0);
      chk_eq("rst_m_rready", m_if.rready, 0);
      chk_eq("rst_s0_arready", s0_if.arready, 0);
      chk_eq("rst_s1_arready", s1_if.arready, 0);
      chk_eq("rst_s0_rvalid", s0_if.rvalid, 0);
      chk_eq("rst_s1_rlast", s1_if.rlast, 0);

      // ---- single request, AR latency and data routing ----
      @(negedge clk);
      arv[0] = 1'b1; addr[0] = 32'h100; alen[0] = 8'd3; m_arready = 1'b1;
      #1;
      chk_eq("lat_arvalid_n", m_if.arvalid, 0);
      @(negedge clk);
      #1;
      chk_eq("lat_arvalid_n1", m_if.arvalid, 1);
      chk_eq("lat_s0_arready", s0_if.arready, 1);
      chk_eq("lat_s1_arready", s1_if.arready, 0);
      chk_eq("lat_araddr", m_if.araddr, 32'h100);
      @(negedge clk);
      arv[0] = 1'b0; m_arready = 1'b0; rrdy[0] = 1'b1;
      for (int b = 0; b < 4; b++) begin
         m_rvalid = 1'b1; m_rdata = 32'hC0DE_0000 + b; m_rresp = 2'b00; m_rlast = (b == 3);
         #1;
         chk_eq("single_s0_rvalid", s0_if.rvalid, 1);
         chk_eq("single_s0_rdata", s0_if.rdata, 32'hC0DE_0000 + b);
         chk_eq("single_s1_rvalid", s1_if.rvalid, 0);
         @(negedge clk);
      end
      m_rvalid = 1'b0; m_rlast = 1'b0;
      #1;
      chk_eq("single_busy_after", busy, 0);
      chk_eq("single_burst_err", burst_err, 0);

      // ---- async reset during beat 2 of 4 ----
      do_reset();
      @(negedge clk);
      arv[0] = 1'b1; addr[0] = 32'h200; alen[0] = 8'd3; m_arready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      arv[0] = 1'b0; m_arready = 1'b0; rrdy[0] = 1'b1;
      for (int b = 0; b < 2; b++) begin
         m_rvalid = 1'b1; m_rdata = 32'hAA00 + b; m_rlast = 1'b0;
         @(negedge clk);
      end
      m_rvalid = 1'b1; m_rdata = 32'hAA02;
      #1;
      chk_eq("arst_pre_s0_rvalid", s0_if.rvalid, 1);
      #1 rst = 1'b1;
      #1;
      chk_eq("arst_busy", busy, 0);
      chk_eq("arst_m_rready", m_if.rready, 0);
      chk_eq("arst_s0_rvalid", s0_if.rvalid, 0);
      @(negedge clk);
      m_rvalid = 1'b0; rrdy[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_last = ~RP;
      arv[0] = 1'b1; arv[1] = 1'b1; alen[0] = 8'd1; alen[1] = 8'd1;
      @(negedge clk);
      #1;
      chk_eq("arst_tie_busy", busy, 1);
      chk_eq("arst_tie_grant", grant_id, RP);

      // ---- table scenarios ----
      for (int i = 0; i < 9; i++) run_traffic(tbl[i], $sformatf("tbl%0d", i));

      // ---- randomized runs against the queue model ----
      for (int k = 0; k < 6; k++) begin
         scen_t sc;
         sc = '{int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), -1, -1, 2, 1, 1, 0, int'(RP)};
         run_traffic(sc, $sformatf("rnd%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
